// File: rtl/axil_slave_mem.sv
// AXI-lite slave backed by a byte-strobed word memory with independent write and read FSMs.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with DECERR instead of SLVERR.
module axil_slave_mem #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         S_AWADDR,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [DATA_W-1:0]   S_WDATA,
  input  logic [DATA_W/8-1:0] S_WSTRB,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  input  logic [31:0]         S_ARADDR,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RVALID,
  input  logic                S_RREADY
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] RESP_ERR  = 2'b11;
`else
  localparam logic [1:0] RESP_ERR  = 2'b10;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  // Low while rst is held so READY stays deasserted without a comb path from rst.
  logic                active_q;
  logic                aw_held, w_held;
  logic [31:0]         aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                aw_fire, w_fire, ar_fire, commit;
  logic [31:0]         wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> BYTE_SH) < 32'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> BYTE_SH);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    S_AWREADY  = 1'b0;
    S_WREADY   = 1'b0;
    S_BVALID   = 1'b0;
    aw_fire    = 1'b0;
    w_fire     = 1'b0;
    commit     = 1'b0;
    wr_addr    = aw_held ? aw_addr_q : S_AWADDR;
    wr_data    = w_held  ? w_data_q  : S_WDATA;
    wr_strb    = w_held  ? w_strb_q  : S_WSTRB;
    w_state_nx = w_state;
    case (w_state)
      W_IDLE: begin
        S_AWREADY = active_q && !aw_held;
        S_WREADY  = active_q && !w_held;
        aw_fire   = S_AWREADY && S_AWVALID;
        w_fire    = S_WREADY && S_WVALID;
        commit    = (aw_held || aw_fire) && (w_held || w_fire);
        if (commit) w_state_nx = W_RESP;
      end
      W_RESP: begin
        S_BVALID = 1'b1;
        if (S_BREADY) w_state_nx = W_IDLE;
      end
    endcase
  end

  always_comb begin
    S_ARREADY  = 1'b0;
    S_RVALID   = 1'b0;
    ar_fire    = 1'b0;
    r_state_nx = r_state;
    case (r_state)
      R_IDLE: begin
        S_ARREADY = active_q;
        ar_fire   = active_q && S_ARVALID;
        if (ar_fire) r_state_nx = R_RESP;
      end
      R_RESP: begin
        S_RVALID = 1'b1;
        if (S_RREADY) r_state_nx = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      S_BRESP   <= RESP_OKAY;
    end else begin
      active_q <= 1'b1;
      w_state  <= w_state_nx;
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AWADDR;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= S_WDATA;
        w_strb_q <= S_WSTRB;
      end
      if (commit) S_BRESP <= in_range(wr_addr) ? RESP_OKAY : RESP_ERR;
      if (w_state == W_RESP && S_BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // NOTE: the memory is cleared on reset because bring-up software relies on a zeroed store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && in_range(wr_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read data is sampled with the old memory contents, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      S_RDATA <= '0;
      S_RRESP <= RESP_OKAY;
    end else begin
      r_state <= r_state_nx;
      if (ar_fire) begin
        S_RDATA <= in_range(S_ARADDR) ? mem[word_idx(S_ARADDR)] : '0;
        S_RRESP <= in_range(S_ARADDR) ? RESP_OKAY : RESP_ERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_mem.sv
// Randomized self-checking bench for axil_slave_mem against a word-array reference model.
module tb_axil_slave_mem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0]  EXP_ERR = 2'b11;
`else
  localparam logic [1:0]  EXP_ERR = 2'b10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  axil_slave_mem #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .S_AWADDR(awaddr), .S_AWVALID(awvalid), .S_AWREADY(awready),
    .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid), .S_WREADY(wready),
    .S_BRESP(bresp), .S_BVALID(bvalid), .S_BREADY(bready),
    .S_ARADDR(araddr), .S_ARVALID(arvalid), .S_ARREADY(arready),
    .S_RDATA(rdata), .S_RRESP(rresp), .S_RVALID(rvalid), .S_RREADY(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_hit(input logic [31:0] a);
    return (a >= BASE) && ((longint'(a) - longint'(BASE)) < DEPTH * 4);
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    return mdl_hit(a) ? mdl[mdl_idx(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] mdl_resp(input logic [31:0] a);
    return mdl_hit(a) ? 2'b00 : EXP_ERR;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (!mdl_hit(a)) return;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    mdl[mdl_idx(a)] = (mdl[mdl_idx(a)] & ~mask) | (d & mask);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"},  wready,  0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_bvalid"},  bvalid,  0);
    check({tag, "_rvalid"},  rvalid,  0);
    check({tag, "_bresp"},   bresp,   0);
    check({tag, "_rresp"},   rresp,   0);
    check({tag, "_rdata"},   rdata,   0);
  endtask

  // Called at a negedge; AW/W offered after aw_lag/w_lag cycles, B accepted after b_wait cycles.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_lag, input int w_lag, input int b_wait);
    bit         aw_done = 0;
    bit         w_done  = 0;
    int         cyc     = 0;
    logic [1:0] er;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 32) begin
      if (aw_done) check("awready_low_wait", awready, 0);
      if (w_done)  check("wready_low_wait",  wready,  0);
      awvalid = !aw_done && (cyc >= aw_lag);
      wvalid  = !w_done  && (cyc >= w_lag);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(negedge clk);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshake_timeout", aw_done && w_done, 1);
    er = mdl_resp(a);
    check("bvalid_next", bvalid, 1);
    check("bresp", bresp, er);
    mdl_write(a, d, s);
    for (int i = 0; i < b_wait; i++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, er);
      check("awready_in_b", awready, 0);
      check("wready_in_b", wready, 0);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("bvalid_clear", bvalid, 0);
    check("awready_after_b", awready, 1);
    check("wready_after_b", wready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_wait);
    logic [31:0] ed;
    logic [1:0]  er;
    bit          done = 0;
    int          cyc  = 0;
    ed = mdl_read(a);
    er = mdl_resp(a);
    araddr = a;
    while (!done && cyc < 32) begin
      arvalid = 1;
      if (arready) done = 1;
      @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    check("rd_handshake_timeout", done, 1);
    check("rvalid_next", rvalid, 1);
    check("rdata", rdata, ed);
    check("rresp", rresp, er);
    last_rdata = rdata;
    for (int i = 0; i < r_wait; i++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, ed);
      check("rresp_hold", rresp, er);
      check("arready_in_r", arready, 0);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("rvalid_clear", rvalid, 0);
    check("arready_after_r", arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 0;
    check("ready_low_until_edge", awready, 0);
    @(negedge clk);
    check("awready_up", awready, 1);
    check("wready_up", wready, 1);
    check("arready_up", arready, 1);

    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(i * 4), 0);

    do_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h08, 0);
    check("simul_write_data", last_rdata, 32'hDEAD_BEEF);

    do_write(32'h08, 32'h1122_3344, 4'b0101, 3, 0, 0);
    do_read(32'h08, 0);
    check("strb_merge", last_rdata, 32'hDE22_BE44);

    do_write(32'h08, 32'hFFFF_FFFF, 4'h0, 0, 2, 0);
    do_read(32'h08, 0);
    check("zero_strb", last_rdata, 32'hDE22_BE44);

    do_write(BASE + 32'(DEPTH * 4), 32'hBAD0_BAD0, 4'hF, 0, 0, 0);
    do_read(BASE + 32'(DEPTH * 4), 0);
    check("oor_rdata", last_rdata, 32'h0);
    do_read(BASE, 0);

    do_write(32'h14, 32'hA5A5_5A5A, 4'hF, 1, 0, 5);
    do_read(32'h14, 5);

    do_write(32'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    fork
      do_write(32'h0C, 32'h55AA_55AA, 4'hF, 0, 0, 0);
      do_read(32'h0C, 0);
    join
    check("same_edge_old_data", last_rdata, 32'hCAFE_F00D);
    do_read(32'h0C, 0);

    for (int it = 0; it < 60; it++) begin
      a = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    do_write(32'h10, 32'h1234_5678, 4'hF, 0, 0, 0);
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    check("rst_test_wready", wready, 1);
    @(negedge clk);
    wvalid = 0;
    awaddr = 32'h10; awvalid = 1; rst = 1;
    @(negedge clk);
    awvalid = 0;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_bvalid_after_rst", bvalid, 0);
    end
    do_read(32'h10, 0);
    check("rst_cleared_word", last_rdata, 32'h0);
    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(i * 4), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
